// File: rtl/apb_uart_pkg.sv
// Shared register addresses and FSM state types for the APB UART slice.
package apb_uart_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_TXDATA = 4'h4;
  localparam logic [3:0] ADDR_RXSTAT = 4'h8;
  localparam logic [3:0] ADDR_RXDATA = 4'hC;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: rxd synchronizer, mid-bit sampling FSM, one-cycle done/frame-error strobes.
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a falling edge
//   RX_START | half a bit in, re-checking the start bit (glitch filter)
//   RX_DATA  | sampling 8 data bits mid-bit, LSB first
//   RX_STOP  | sampling the stop bit, then strobing done or frame error
module uart_rx_core
  import apb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_rxd,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_done,
  output logic       o_rx_ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_rxd_q;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_done;
  logic             r_ferr;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state   <= RX_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rxd_q   <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_rxd_q <= r_sync2;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_rxd_q && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= HALF_BIT;
          end
        end
        RX_START: begin
          if (r_cnt == '0) begin
            if (!r_sync2) begin
              r_state   <= RX_DATA;
              r_cnt     <= FULL_BIT;
              r_bit_idx <= '0;
            end else begin
              r_state <= RX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {r_sync2, r_shift[7:1]};
            r_cnt   <= FULL_BIT;
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == '0) begin
            r_done  <= r_sync2;
            r_ferr  <= !r_sync2;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_byte = r_shift;
  assign o_rx_done = r_done;
  assign o_rx_ferr = r_ferr;

endmodule

// File: rtl/apb_uart_ctrl.sv
// APB3 UART: register file, 8N1 transmitter FSM and RX status flags around uart_rx_core.
//   state    | meaning
//   TX_IDLE  | txd high, waiting for a start command
//   TX_START | driving the start bit
//   TX_DATA  | shifting out 8 data bits, LSB first
//   TX_STOP  | driving the stop bit; busy drops when it ends
module apb_uart_ctrl
  import apb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        rxd,
  output logic        txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        r_tx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_bit_idx;
  logic [7:0]       r_tx_shift;
  logic [7:0]       r_tx_data;
  logic             r_tx_busy;
  logic             r_txd;

  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_rx_overrun;
  logic             r_rx_frame_err;

  logic             w_wr;
  logic             w_start;
  logic             w_rd_clr;
  logic [7:0]       w_rx_byte;
  logic             w_rx_done;
  logic             w_rx_ferr;
  logic [31:0]      w_prdata;

  assign w_wr     = psel && penable && pwrite;
  assign w_start  = w_wr && (paddr == ADDR_CTRL) && pwdata[0];
  assign w_rd_clr = psel && penable && !pwrite && (paddr == ADDR_RXDATA);

  always_comb begin
    w_prdata = '0;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_CTRL:   w_prdata[0]   = r_tx_busy;
        ADDR_TXDATA: w_prdata[7:0] = r_tx_data;
        ADDR_RXSTAT: w_prdata[2:0] = {r_rx_frame_err, r_rx_overrun, r_rx_valid};
        ADDR_RXDATA: w_prdata[7:0] = r_rx_data;
        default:     w_prdata      = '0;
      endcase
    end
  end

  assign prdata  = w_prdata;
  assign pready  = 1'b1;
  assign pslverr = 1'b0;
  assign txd     = r_txd;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_tx_data <= '0;
    end else if (w_wr && (paddr == ADDR_TXDATA)) begin
      r_tx_data <= pwdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_tx_state   <= TX_IDLE;
      r_tx_cnt     <= '0;
      r_tx_bit_idx <= '0;
      r_tx_shift   <= '0;
      r_tx_busy    <= 1'b0;
      r_txd        <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          // Snapshot the holding register so later TXDATA writes leave this frame alone.
          if (w_start) begin
            r_tx_shift <= r_tx_data;
            r_tx_busy  <= 1'b1;
            r_txd      <= 1'b0;
            r_tx_cnt   <= FULL_BIT;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == '0) begin
            r_txd        <= r_tx_shift[0];
            r_tx_cnt     <= FULL_BIT;
            r_tx_bit_idx <= '0;
            r_tx_state   <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= FULL_BIT;
            if (r_tx_bit_idx == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_txd        <= r_tx_shift[1];
              r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit_idx <= r_tx_bit_idx + 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == '0) begin
            r_tx_busy  <= 1'b0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .i_rxd     (rxd),
    .o_rx_byte (w_rx_byte),
    .o_rx_done (w_rx_done),
    .o_rx_ferr (w_rx_ferr)
  );

  // Later assignments take priority: a byte landing during an RXDATA read stays valid without overrun.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      if (w_rd_clr) begin
        r_rx_valid     <= 1'b0;
        r_rx_overrun   <= 1'b0;
        r_rx_frame_err <= 1'b0;
      end
      if (w_rx_ferr) r_rx_frame_err <= 1'b1;
      if (w_rx_done) begin
        r_rx_data    <= w_rx_byte;
        r_rx_valid   <= 1'b1;
        r_rx_overrun <= !w_rd_clr && (r_rx_overrun || r_rx_valid);
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Bench for a cross-connected pair of apb_uart_ctrl instances, checked against a byte-level model.
module tb_apb_uart_ctrl;
  import apb_uart_pkg::*;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  paddr = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        psel0 = 1'b0;
  logic        psel1 = 1'b0;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic        txd0, txd1;
  logic        drv0 = 1'b0;
  logic        tb_rxd0 = 1'b1;
  logic        rxd0;

  assign rxd0 = drv0 ? tb_rxd0 : txd1;

  always #5 clk = ~clk;

  apb_uart_ctrl #(.CLKS_PER_BIT(CPB)) u0 (
    .clk(clk), .rstn(rstn), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .rxd(rxd0), .txd(txd0)
  );

  apb_uart_ctrl #(.CLKS_PER_BIT(CPB)) u1 (
    .clk(clk), .rstn(rstn), .paddr(paddr), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .rxd(txd0), .txd(txd1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what each receiver should hold, as whole bytes and flags.
  logic [7:0] m_data  [2];
  bit         m_valid [2];
  bit         m_ovr   [2];
  bit         m_ferr  [2];
  logic [7:0] exp_q[$];
  logic [7:0] mon_q[$];
  logic [7:0] mon_b;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = 8'h00; m_valid[i] = 0; m_ovr[i] = 0; m_ferr[i] = 0;
    end
  endfunction

  function automatic void m_deliver(input int dst, input logic [7:0] b);
    if (m_valid[dst]) m_ovr[dst] = 1;
    m_data[dst]  = b;
    m_valid[dst] = 1;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic apb_wr(input int idx, input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    paddr = a; pwdata = d; pwrite = 1'b1; penable = 1'b0;
    if (idx == 0) psel0 = 1'b1; else psel1 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input int idx, input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    paddr = a; pwrite = 1'b0; penable = 1'b0;
    if (idx == 0) psel0 = 1'b1; else psel1 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    d = (idx == 0) ? prdata0 : prdata1;
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_tx_done(input int idx, input string name);
    logic [31:0] d;
    int n = 0;
    do begin
      apb_rd(idx, ADDR_CTRL, d);
      n++;
    end while (d[0] && n < 200);
    if (d[0]) timeout_fail(name);
  endtask

  task automatic send_byte(input int src, input logic [7:0] b);
    apb_wr(src, ADDR_TXDATA, {24'h0, b});
    apb_wr(src, ADDR_CTRL, 32'h1);
    m_deliver(1 - src, b);
    if (src == 0) exp_q.push_back(b);
  endtask

  // Read RXSTAT, RXDATA, then RXSTAT again, comparing against the model and draining it.
  task automatic check_rx(input int idx, input string name);
    logic [31:0] d;
    apb_rd(idx, ADDR_RXSTAT, d);
    chk({name, "_rxstat"}, d, {29'h0, m_ferr[idx], m_ovr[idx], m_valid[idx]});
    apb_rd(idx, ADDR_RXDATA, d);
    chk({name, "_rxdata"}, d, {24'h0, m_data[idx]});
    m_valid[idx] = 0; m_ovr[idx] = 0; m_ferr[idx] = 0;
    apb_rd(idx, ADDR_RXSTAT, d);
    chk({name, "_rxstat_cleared"}, d, 32'h0);
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    tb_rxd0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk); #1;
      tb_rxd0 = b[i];
    end
    repeat (CPB) @(posedge clk); #1;
    tb_rxd0 = stop;
    repeat (CPB) @(posedge clk); #1;
    tb_rxd0 = 1'b1;
  endtask

  // Serial monitor on txd0: decodes frames mid-bit into mon_q.
  initial begin
    forever begin
      @(negedge txd0);
      repeat (CPB / 2) @(posedge clk);
      if (txd0 === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          mon_b[i] = txd0;
        end
        mon_q.push_back(mon_b);
      end
    end
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] old;
    int src;
    logic [7:0] b;

    m_reset();
    wait_cycles(4);
    #1;
    chk("reset_txd0", {31'h0, txd0}, 32'h1);
    chk("reset_txd1", {31'h0, txd1}, 32'h1);
    chk("pready0", {31'h0, pready0}, 32'h1);
    chk("pslverr0", {31'h0, pslverr0}, 32'h0);
    chk("pready1", {31'h0, pready1}, 32'h1);
    chk("pslverr1", {31'h0, pslverr1}, 32'h0);
    chk("prdata_idle", prdata0, 32'h0);
    @(negedge clk);
    rstn = 1'b0;

    vecs.push_back('{0, ADDR_CTRL,   32'h0,         32'h0});
    vecs.push_back('{0, ADDR_TXDATA, 32'h0,         32'h0});
    vecs.push_back('{0, ADDR_RXSTAT, 32'h0,         32'h0});
    vecs.push_back('{0, ADDR_RXDATA, 32'h0,         32'h0});
    vecs.push_back('{1, ADDR_TXDATA, 32'h0000_00A5, 32'h0});
    vecs.push_back('{0, ADDR_TXDATA, 32'h0,         32'h0000_00A5});
    vecs.push_back('{0, 4'h5,        32'h0,         32'h0});
    vecs.push_back('{1, ADDR_TXDATA, 32'hFFFF_FF3C, 32'h0});
    vecs.push_back('{0, ADDR_TXDATA, 32'h0,         32'h0000_003C});
    vecs.push_back('{1, 4'h2,        32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{0, 4'h2,        32'h0,         32'h0});
    vecs.push_back('{1, ADDR_RXSTAT, 32'h7,         32'h0});
    vecs.push_back('{0, ADDR_RXSTAT, 32'h0,         32'h0});
    vecs.push_back('{1, ADDR_RXDATA, 32'hFF,        32'h0});
    vecs.push_back('{0, ADDR_RXDATA, 32'h0,         32'h0});
    vecs.push_back('{1, ADDR_CTRL,   32'h2,         32'h0});
    vecs.push_back('{0, ADDR_CTRL,   32'h0,         32'h0});
    vecs.push_back('{0, 4'hF,        32'h0,         32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        apb_wr(0, vecs[i].addr, vecs[i].data);
      end else begin
        apb_rd(0, vecs[i].addr, d);
        chk($sformatf("vec%0d_addr%0h", i, vecs[i].addr), d, vecs[i].exp);
      end
    end
    wait_cycles(2);
    #1;
    chk("no_frame_from_ctrl_bit1", {31'h0, txd0}, 32'h1);

    // Loopback pair with exact busy-window check on UART0.
    apb_wr(0, ADDR_TXDATA, 32'h12);
    apb_wr(1, ADDR_TXDATA, 32'h34);
    apb_wr(1, ADDR_CTRL, 32'h1);
    apb_wr(0, ADDR_CTRL, 32'h1);
    m_deliver(1, 8'h12); m_deliver(0, 8'h34); exp_q.push_back(8'h12);
    wait_cycles(155);
    apb_rd(0, ADDR_CTRL, d);
    chk("busy_before_frame_end", d, 32'h1);
    apb_rd(0, ADDR_CTRL, d);
    chk("busy_after_frame_end", d, 32'h0);
    wait_cycles(20);
    check_rx(0, "loop_u0");
    check_rx(1, "loop_u1");

    // Overrun on UART0, single byte on UART1.
    apb_wr(1, ADDR_TXDATA, 32'h56);
    apb_wr(0, ADDR_TXDATA, 32'h56);
    apb_wr(1, ADDR_CTRL, 32'h1);
    apb_wr(0, ADDR_CTRL, 32'h1);
    m_deliver(0, 8'h56); m_deliver(1, 8'h56); exp_q.push_back(8'h56);
    wait_tx_done(1, "ovr_tx1a");
    wait_tx_done(0, "ovr_tx0");
    send_byte(1, 8'h78);
    wait_tx_done(1, "ovr_tx1b");
    wait_cycles(10);
    chk("ovr_model_sanity", {31'h0, m_ovr[0]}, 32'h1);
    check_rx(0, "ovr_u0");
    check_rx(1, "ovr_u1");

    // Start and TXDATA writes during a frame must not disturb it.
    wait_cycles(10);
    mon_q.delete(); exp_q.delete();
    send_byte(0, 8'hC3);
    wait_cycles(50);
    apb_wr(0, ADDR_CTRL, 32'h1);
    apb_wr(0, ADDR_TXDATA, 32'hAA);
    wait_tx_done(0, "busy_prot_tx");
    wait_cycles(200);
    chk("busy_prot_frames", mon_q.size(), 1);
    if (mon_q.size() > 0) chk("busy_prot_byte", {24'h0, mon_q[0]}, 32'hC3);
    apb_rd(0, ADDR_TXDATA, d);
    chk("busy_prot_txdata", d, 32'hAA);
    check_rx(1, "busy_prot_u1");
    check_rx(0, "busy_prot_u0");

    // Randomized traffic with occasional draining; overruns arise naturally.
    mon_q.delete(); exp_q.delete();
    for (int it = 0; it < 8; it++) begin
      src = int'($urandom_range(0, 1));
      b = 8'($urandom_range(0, 255));
      send_byte(src, b);
      wait_tx_done(src, $sformatf("rand%0d_tx", it));
      wait_cycles(10);
      if ($urandom_range(0, 2) == 0) check_rx(int'($urandom_range(0, 1)), $sformatf("rand%0d", it));
    end
    check_rx(0, "rand_end_u0");
    check_rx(1, "rand_end_u1");
    chk("rand_frames", mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk($sformatf("rand_frame%0d", i), {24'h0, mon_q[i]}, {24'h0, exp_q[i]});

    // Bench-driven serial line into UART0: glitch, frame error, read/store collision.
    wait_cycles(5);
    drv0 = 1'b1;
    @(posedge clk); #1;
    tb_rxd0 = 1'b0;
    repeat (4) @(posedge clk); #1;
    tb_rxd0 = 1'b1;
    wait_cycles(200);
    apb_rd(0, ADDR_RXSTAT, d);
    chk("glitch_rxstat", d, 32'h0);

    send_serial(8'h5A, 1'b0);
    wait_cycles(20);
    m_ferr[0] = 1;
    apb_rd(0, ADDR_RXSTAT, d);
    chk("ferr_rxstat", d, 32'h4);
    check_rx(0, "ferr");

    send_serial(8'h11, 1'b1);
    m_deliver(0, 8'h11);
    wait_cycles(20);
    old = {24'h0, m_data[0]};
    fork
      send_serial(8'h22, 1'b1);
      begin
        wait_cycles(154);
        apb_rd(0, ADDR_RXDATA, d);
      end
    join
    chk("collide_read_old", d, old);
    m_data[0] = 8'h22; m_valid[0] = 1; m_ovr[0] = 0; m_ferr[0] = 0;
    wait_cycles(10);
    check_rx(0, "collide");
    drv0 = 1'b0;

    // Reset in the middle of a frame.
    wait_cycles(10);
    apb_wr(0, ADDR_TXDATA, 32'h00);
    apb_wr(0, ADDR_CTRL, 32'h1);
    wait_cycles(40);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("midreset_txd0", {31'h0, txd0}, 32'h1);
    wait_cycles(3);
    @(negedge clk);
    rstn = 1'b0;
    m_reset();
    apb_rd(0, ADDR_CTRL, d);
    chk("midreset_busy", d, 32'h0);
    apb_rd(0, ADDR_TXDATA, d);
    chk("midreset_txdata", d, 32'h0);
    wait_cycles(200);
    check_rx(1, "midreset_u1");
    check_rx(0, "midreset_u0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_uart_ctrl.md
Name: apb_uart_ctrl

Overview:
- APB3 slave UART, one per serial link. Fixed 8N1 framing, single-byte TX holding register, single-byte RX buffer.
- CPU writes a byte and a start command, polls TX busy, then polls RX valid and reads the received byte.
- Instantiated in pairs with txd/rxd cross-connected; psel decoding is done outside the block.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (must be ≥4 and even).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-high.
- paddr  in  4  APB byte address (word-aligned registers).
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  always 1 (zero wait states).
- pslverr  out  1  always 0.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- txd  out  1  serial output, idle high.

Behaviour:
- Reset (rstn = 1): txd = 1, tx_busy = 0, tx_data = 0, rx_valid = 0, rx_data = 0, rx_overrun = 0, rx_frame_err = 0. prdata = 0.
- APB write commits on a clk edge with psel & penable & pwrite. Read is combinational: prdata = register(paddr) while psel & !pwrite, else 0. No wait states.
- Register map (paddr[3:0]); unused bits read 0:
  - 0x0 CTRL/STAT: write bit0 = 1 starts TX if idle; ignored while busy. Read bit0 = tx_busy.
  - 0x4 TXDATA: R/W, bits [7:0].
  - 0x8 RXSTAT: read only. bit0 = rx_valid, bit1 = rx_overrun, bit2 = rx_frame_err.
  - 0xC RXDATA: read returns rx_data[7:0]. The access phase (psel & penable & !pwrite) clears rx_valid, rx_overrun and rx_frame_err.
  - Any other address reads 0; writes to it are ignored.
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - Start command copies tx_data into the shift register and sets tx_busy on the next edge. Later TXDATA writes do not affect the frame in flight.
  - txd = 0 for the start bit, then 8 data bits LSB first, then 1 for the stop bit. Each bit lasts CLKS_PER_BIT cycles.
  - tx_busy clears when the stop bit ends. Frame length is 10·CLKS_PER_BIT cycles.
- RX FSM, states IDLE → START → DATA → STOP:
  - rxd passes through a 2-flop synchronizer.
  - A falling edge in IDLE starts a frame. At CLKS_PER_BIT/2 the start bit is rechecked; if high, it was a glitch and the FSM returns to IDLE.
  - Data bits are sampled mid-bit, LSB first. The stop bit is sampled mid-bit.
  - Stop = 1: load rx_data and set rx_valid. If rx_valid was already 1, also set rx_overrun (new data overwrites old).
  - Stop = 0: set rx_frame_err and discard the byte.
  - The FSM returns to IDLE after the stop-bit sample.
- Simultaneous events: if an RXDATA read coincides with a new byte being stored, the new byte wins (rx_valid stays 1, overrun is not set).
- Reset mid-frame aborts TX or RX immediately: txd goes to 1 and the FSMs go to IDLE.

Decomposition:
- Shared package apb_uart_pkg:
  - address constants ADDR_CTRL = 4'h0, ADDR_TXDATA = 4'h4, ADDR_RXSTAT = 4'h8, ADDR_RXDATA = 4'hC;
  - enum typedefs for the tx and rx states.
- The top level holds the APB register file and the TX FSM.
- One sub-module, uart_rx_core: synchronizer, RX FSM, byte/valid/frame_err outputs.

Test Plan:
- Reset: assert rstn → txd = 1, all reads return 0, pready = 1, pslverr = 0.
- Loopback pair: write TXDATA = 0x12 on UART0 and 0x34 on UART1, CTRL = 1 on both.
  - UART0 CTRL reads 1 until about 160 cycles have elapsed, then 0.
  - Afterwards UART0 RXSTAT = 1 and RXDATA = 0x34; UART1 RXDATA = 0x12.
- Read clear: after an RXDATA read, RXSTAT = 0.
- Overrun: send 0x56 and 0x78 without draining the receivers.
  - UART0 RXSTAT = 3, RXDATA = 0x78; UART1 RXDATA = 0x56.
- Busy protection: write CTRL = 1 and TXDATA = 0xAA mid-frame → the frame in flight is unchanged and no extra frame is sent.
- Glitch/frame error:
  - Drive rxd low for 4 cycles → nothing received.
  - Send a frame with stop = 0 → RXSTAT bit2 = 1 and rx_valid = 0.
